// File: rtl/sha3_msg_sequencer.sv
// rtl/sha3_msg_sequencer.sv - feeds one message into sha3_low_throughput and captures its 512-bit digest
// Optional digest-wait watchdog enabled by defining SHA3_SEQ_WATCHDOG_EN.
module sha3_msg_sequencer #(
  parameter int LEN_W       = 16,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  input  logic [31:0]      src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             core_reset,
  output logic [31:0]      core_in,
  output logic             core_in_ready,
  output logic             core_is_last,
  output logic [1:0]       core_byte_num,
  input  logic             core_buffer_full,
  input  logic [511:0]     core_out,
  input  logic             core_out_ready,
  output logic [511:0]     digest,
  output logic             digest_valid,
  input  logic             digest_ack,
  output logic             error
);

  localparam int NW_W = LEN_W - 2;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_FEED,
    S_LAST,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NW_W-1:0] nwords;
  logic [1:0]      rem;
  logic            can_issue;
  logic            src_hs;
  logic            empty_issue;
  logic            wdog_expire;

  // One word per two cycles at most, so buffer_full always reflects the previous word.
  assign can_issue   = !core_buffer_full && !core_in_ready;
  assign src_hs      = src_valid && src_ready;
  assign empty_issue = (state == S_LAST) && (rem == 2'd0) && can_issue;

`ifdef SHA3_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != S_WAIT) begin
      wdog_cnt <= '0;
    end else if (wdog_cnt != WDOG_W'(WDOG_CYCLES - 1)) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end

  assign wdog_expire = (state == S_WAIT) && !core_out_ready &&
                       (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: state_nxt = S_IDLE;
      S_IDLE: begin
        if (start) begin
          state_nxt = (msg_len[LEN_W-1:2] != '0) ? S_FEED : S_LAST;
        end
      end
      S_FEED: begin
        if (src_hs && nwords == NW_W'(1)) begin
          state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        if ((rem != 2'd0) ? src_hs : empty_issue) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_out_ready) begin
          state_nxt = S_HOLD;
        end else if (wdog_expire) begin
          state_nxt = S_CLEAR;
        end
      end
      S_HOLD: begin
        if (digest_ack) begin
          state_nxt = S_CLEAR;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    src_ready  = 1'b0;
    core_reset = reset;
    case (state)
      S_CLEAR: core_reset = 1'b1;
      S_IDLE:  busy = 1'b0;
      S_FEED: begin
        busy      = 1'b1;
        src_ready = can_issue;
      end
      S_LAST: begin
        busy      = 1'b1;
        src_ready = (rem != 2'd0) && can_issue;
      end
      S_WAIT:  busy = 1'b1;
      S_HOLD:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Core strobes are single-cycle pulses; data and byte count hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      nwords        <= '0;
      rem           <= 2'd0;
      core_in       <= 32'h0;
      core_in_ready <= 1'b0;
      core_is_last  <= 1'b0;
      core_byte_num <= 2'd0;
      digest        <= '0;
      digest_valid  <= 1'b0;
      error         <= 1'b0;
    end else begin
      core_in_ready <= 1'b0;
      core_is_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            nwords <= msg_len[LEN_W-1:2];
            rem    <= msg_len[1:0];
            error  <= 1'b0;
          end
        end
        S_FEED: begin
          if (src_hs) begin
            core_in       <= src_data;
            core_in_ready <= 1'b1;
            core_byte_num <= 2'd0;
            nwords        <= nwords - NW_W'(1);
          end
        end
        S_LAST: begin
          if (rem != 2'd0 && src_hs) begin
            core_in       <= src_data;
            core_in_ready <= 1'b1;
            core_is_last  <= 1'b1;
            core_byte_num <= rem;
          end else if (empty_issue) begin
            core_in       <= 32'h0;
            core_in_ready <= 1'b1;
            core_is_last  <= 1'b1;
            core_byte_num <= 2'd0;
          end
        end
        S_WAIT: begin
          if (core_out_ready) begin
            digest       <= core_out;
            digest_valid <= 1'b1;
          end else if (wdog_expire) begin
            error <= 1'b1;
          end
        end
        S_HOLD: begin
          if (digest_ack) begin
            digest_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_msg_sequencer.sv
// tb/tb_sha3_msg_sequencer.sv - directed bench for sha3_msg_sequencer with a behavioural core stub
module tb_sha3_msg_sequencer;

  localparam logic [511:0] SHA3_EMPTY = 512'ha69f73cca23a9ac5c8b567dc185a756e97c982164fe25859e0d1dcc1475c80a615b2123af1f5f94c11e3e9402c3ac558f500199d95b6d3e301758586281dcd26;
  localparam logic [511:0] SHA3_ABC   = 512'hb751850b1a57168a5693cd924b6b096e08f621827444f70d884f5d0240d2712e10e116e9192af3c91a7ec57647e3934057340b4cf408d5a56592f8274eec53f0;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  msg_len;
  logic         busy;
  logic [31:0]  src_data;
  logic         src_valid;
  logic         src_ready;
  logic         core_reset;
  logic [31:0]  core_in;
  logic         core_in_ready;
  logic         core_is_last;
  logic [1:0]   core_byte_num;
  logic         core_buffer_full = 1'b0;
  logic [511:0] core_out = '0;
  logic         core_out_ready = 1'b0;
  logic [511:0] digest;
  logic         digest_valid;
  logic         digest_ack;
  logic         error;

  always #5 clk = ~clk;

  sha3_msg_sequencer #(.LEN_W(16), .WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len), .busy(busy),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .core_reset(core_reset), .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out),
    .core_out_ready(core_out_ready), .digest(digest), .digest_valid(digest_valid),
    .digest_ack(digest_ack), .error(error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Message source: queue of words, optional valid gaps.
  logic [31:0] src_q[$];
  int          src_reads = 0;
  bit          src_gaps = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    src_valid = (src_q.size() != 0) && !(src_gaps && (cyc % 3 == 0));
    src_data  = src_valid ? src_q[0] : 32'h0;
  end

  always @(posedge clk) begin
    if (src_valid && src_ready) begin
      void'(src_q.pop_front());
      src_reads++;
    end
  end

  // Core stub: records pulses, raises buffer_full after every 4th word, returns a digest after the last.
  logic [34:0]  rx_q[$];
  int           bf_viol = 0;
  int           bf_hold = 0;
  int           lat = 0;
  bit           pending = 0;
  bit           stall_out = 0;
  bit           use_acc = 0;
  bit           prev_ir = 0;
  logic [511:0] known = '0;
  logic [31:0]  acc = 32'h0;

  always @(posedge clk) begin
    if (core_reset) begin
      rx_q.delete();
      core_buffer_full <= 1'b0;
      core_out_ready   <= 1'b0;
      core_out         <= '0;
      bf_hold = 0;
      pending = 0;
      prev_ir = 0;
      acc     = 32'h0;
    end else begin
      if (core_in_ready) begin
        if (core_buffer_full || prev_ir) bf_viol++;
        rx_q.push_back({core_is_last, core_byte_num, core_in});
        acc = ((acc << 5) + acc) ^ core_in;
        if (rx_q.size() % 4 == 0) begin
          core_buffer_full <= 1'b1;
          bf_hold = 3;
        end
        if (core_is_last) begin
          pending = 1;
          lat     = 4;
        end
      end else if (bf_hold > 0) begin
        bf_hold--;
        if (bf_hold == 0) core_buffer_full <= 1'b0;
      end
      prev_ir = core_in_ready;
      if (pending && !stall_out) begin
        if (lat == 0) begin
          core_out_ready <= 1'b1;
          core_out       <= use_acc ? {16{acc}} : known;
          pending = 0;
        end else begin
          lat--;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_msg(input int len);
    msg_len = 16'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_dv(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (digest_valid) break;
      tick();
    end
    check(tag, 512'(digest_valid), 512'(1));
  endtask

  task automatic ack_digest(input logic [511:0] exp);
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    check("ack_dv_low", 512'(digest_valid), 512'(0));
    check("ack_digest_held", digest, exp);
    check("ack_clear_pulse", 512'(core_reset), 512'(1));
    tick();
    check("ack_clear_done", 512'(core_reset), 512'(0));
    check("ack_idle", 512'(busy), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [31:0] exp_acc;
    int          bad;
    int          t0;
    int          t1;

    reset = 1'b1; start = 1'b0; msg_len = '0; digest_ack = 1'b0;
    tick(3);
    check("rst_core_reset", 512'(core_reset), 512'(1));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_src_ready", 512'(src_ready), 512'(0));
    check("rst_in_ready", 512'(core_in_ready), 512'(0));
    check("rst_is_last", 512'(core_is_last), 512'(0));
    check("rst_core_in", 512'(core_in), 512'(0));
    check("rst_dv", 512'(digest_valid), 512'(0));
    check("rst_digest", digest, '0);
    check("rst_error", 512'(error), 512'(0));
    reset = 1'b0;
    #1;
    check("clear_after_rst", 512'(core_reset), 512'(1));
    tick();
    check("idle_after_clear", 512'(core_reset), 512'(0));

    // Empty message: one empty last word, source never read.
    known = SHA3_EMPTY; use_acc = 0; src_reads = 0;
    start_msg(0);
    check("m0_busy", 512'(busy), 512'(1));
    wait_dv("m0_dv");
    check("m0_npulse", 512'(rx_q.size()), 512'(1));
    check("m0_word", 512'(rx_q[0]), 512'({1'b1, 2'd0, 32'h0}));
    check("m0_reads", 512'(src_reads), 512'(0));
    check("m0_digest", digest, SHA3_EMPTY);
    ack_digest(SHA3_EMPTY);

    // "abc": one partial last word; start coincident with ack is dropped.
    known = SHA3_ABC; src_reads = 0;
    src_q.push_back(32'h61626300);
    start_msg(3);
    wait_dv("abc_dv");
    check("abc_npulse", 512'(rx_q.size()), 512'(1));
    check("abc_word", 512'(rx_q[0]), 512'({1'b1, 2'd3, 32'h61626300}));
    check("abc_reads", 512'(src_reads), 512'(1));
    check("abc_digest", digest, SHA3_ABC);
    digest_ack = 1'b1; start = 1'b1; msg_len = 16'd3;
    tick();
    digest_ack = 1'b0; start = 1'b0;
    check("ackstart_dv", 512'(digest_valid), 512'(0));
    tick(4);
    check("ackstart_lost_busy", 512'(busy), 512'(0));
    check("ackstart_lost_pulses", 512'(rx_q.size()), 512'(0));

    // 8 bytes: two full words then a separate empty last word.
    src_reads = 0;
    src_q.push_back(32'h11223344);
    src_q.push_back(32'h55667788);
    start_msg(8);
    wait_dv("m8_dv");
    check("m8_npulse", 512'(rx_q.size()), 512'(3));
    check("m8_w0", 512'({rx_q[0][34], rx_q[0][31:0]}), 512'({1'b0, 32'h11223344}));
    check("m8_w1", 512'({rx_q[1][34], rx_q[1][31:0]}), 512'({1'b0, 32'h55667788}));
    check("m8_w2", 512'(rx_q[2]), 512'({1'b1, 2'd0, 32'h0}));
    check("m8_reads", 512'(src_reads), 512'(2));
    ack_digest(SHA3_ABC);

    // 200 bytes with source gaps and buffer_full back-pressure.
    src_reads = 0; src_gaps = 1; use_acc = 1; exp_acc = 32'h0;
    for (int i = 0; i < 50; i++) begin
      w = 32'(i + 1) * 32'h9E3779B9;
      src_q.push_back(w);
      exp_acc = ((exp_acc << 5) + exp_acc) ^ w;
    end
    exp_acc = ((exp_acc << 5) + exp_acc);
    start_msg(200);
    wait_dv("m200_dv");
    check("m200_npulse", 512'(rx_q.size()), 512'(51));
    check("m200_reads", 512'(src_reads), 512'(50));
    check("m200_bf_viol", 512'(bf_viol), 512'(0));
    bad = 0;
    for (int i = 0; i < 50 && i < rx_q.size(); i++) begin
      if (rx_q[i][34] !== 1'b0 || rx_q[i][31:0] !== 32'(i + 1) * 32'h9E3779B9) bad++;
    end
    check("m200_words", 512'(bad), 512'(0));
    if (rx_q.size() == 51) check("m200_last", 512'(rx_q[50]), 512'({1'b1, 2'd0, 32'h0}));
    check("m200_digest", digest, {16{exp_acc}});
    ack_digest({16{exp_acc}});
    src_gaps = 0; use_acc = 0;

    // Reset while feeding the fifth word, then a clean "abc".
    for (int i = 0; i < 10; i++) src_q.push_back(32'hC0DE0000 + 32'(i));
    start_msg(40);
    for (int i = 0; i < 500; i++) begin
      if (rx_q.size() >= 5) break;
      tick();
    end
    check("mid_reached_w5", 512'(rx_q.size()), 512'(5));
    reset = 1'b1;
    tick();
    check("mid_rst_core_reset", 512'(core_reset), 512'(1));
    check("mid_rst_busy", 512'(busy), 512'(0));
    reset = 1'b0;
    src_q.delete();
    #1;
    check("mid_clear", 512'(core_reset), 512'(1));
    tick();
    check("mid_clear_done", 512'(core_reset), 512'(0));
    check("mid_idle", 512'(busy), 512'(0));
    check("mid_no_digest", 512'(digest_valid), 512'(0));
    known = SHA3_ABC;
    src_q.push_back(32'h61626300);
    start_msg(3);
    wait_dv("post_abc_dv");
    check("post_abc_word", 512'(rx_q[0]), 512'({1'b1, 2'd3, 32'h61626300}));
    check("post_abc_digest", digest, SHA3_ABC);
    ack_digest(SHA3_ABC);

    // Digest never arrives.
    stall_out = 1;
    start_msg(0);
`ifdef SHA3_SEQ_WATCHDOG_EN
    t0 = -1; t1 = -1;
    for (int i = 0; i < 200; i++) begin
      if (core_in_ready && core_is_last) t0 = i;
      if (error) begin
        t1 = i;
        break;
      end
      tick();
    end
    check("wdog_latency", 512'(t1 - t0), 512'(16));
    check("wdog_error", 512'(error), 512'(1));
    check("wdog_no_dv", 512'(digest_valid), 512'(0));
    check("wdog_clear", 512'(core_reset), 512'(1));
    tick();
    check("wdog_idle", 512'(busy), 512'(0));
    stall_out = 0;
    known = SHA3_EMPTY;
    start_msg(0);
    check("wdog_err_cleared", 512'(error), 512'(0));
    wait_dv("wdog_next_dv");
    check("wdog_next_digest", digest, SHA3_EMPTY);
    ack_digest(SHA3_EMPTY);
`else
    tick(40);
    check("nowdog_error", 512'(error), 512'(0));
    check("nowdog_waiting", 512'(busy), 512'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall_out = 0;
    tick(2);
    check("nowdog_idle", 512'(busy), 512'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
